// File: rtl/riscv_pkg.sv
// Shared RV64 constants for the writeback stage: datapath width and the
// load funct3 encodings.
package riscv_pkg;

  localparam int XLEN = 64;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/load_extend.sv
// Byte-lane selection and sign/zero extension of a doubleword-aligned load,
// plus detection of misaligned or illegal load encodings.
module load_extend
  import riscv_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [2:0]   funct3,
  input  logic [2:0]   addr,
  input  logic [W-1:0] read_data,
  output logic [W-1:0] ext_data,
  output logic         misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] word_sel;

  always_comb begin
    byte_sel   = read_data[{addr, 3'b000} +: 8];
    half_sel   = read_data[{addr[2:1], 4'b0000} +: 16];
    word_sel   = read_data[{addr[2], 5'b00000} +: 32];
    ext_data   = '0;
    misaligned = 1'b0;
    case (funct3)
      F3_LB:  ext_data = {{(W-8){byte_sel[7]}}, byte_sel};
      F3_LBU: ext_data = {{(W-8){1'b0}}, byte_sel};
      F3_LH: begin
        ext_data   = {{(W-16){half_sel[15]}}, half_sel};
        misaligned = addr[0];
      end
      F3_LHU: begin
        ext_data   = {{(W-16){1'b0}}, half_sel};
        misaligned = addr[0];
      end
      F3_LW: begin
        ext_data   = {{(W-32){word_sel[31]}}, word_sel};
        misaligned = |addr[1:0];
      end
      F3_LWU: begin
        ext_data   = {{(W-32){1'b0}}, word_sel};
        misaligned = |addr[1:0];
      end
      F3_LD: begin
        ext_data   = read_data;
        misaligned = |addr;
      end
      // The one remaining encoding is illegal: no data, flagged as misaligned.
      default: begin
        ext_data   = '0;
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Memory-to-writeback pipeline register: captures one instruction, extends
// loads, drives the register-file write port, forwarding bus and instret.
module wb_stage #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic             wb_stall,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  read_data,
  input  logic [4:0]       rd,
  input  logic             reg_write,
  input  logic             mem_to_reg,
  input  logic             mem_read,
  input  logic [2:0]       funct3,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic             load_misaligned,
  output logic [CNT_W-1:0] instret
);

  logic             v_q, v_d;
  logic [4:0]       rd_q, rd_d;
  logic             reg_write_q, reg_write_d;
  logic             mis_q, mis_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic [XLEN-1:0]  ext_data;
  logic             ext_mis;
  logic             capture;
  logic             retire;
  logic             writes;

  load_extend #(.W(XLEN)) u_load_extend (
    .funct3     (funct3),
    .addr       (alu_result[2:0]),
    .read_data  (read_data),
    .ext_data   (ext_data),
    .misaligned (ext_mis)
  );

  assign in_ready = ~v_q | ~wb_stall;

  always_comb begin
    capture     = in_valid & in_ready & ~flush;
    retire      = v_q & ~wb_stall;
    v_d         = v_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    mis_d       = mis_q;
    wdata_d     = wdata_q;
    instret_d   = instret_q + CNT_W'(retire);

    // Flush beats capture; a held entry that retires this cycle still counts.
    if (flush) begin
      v_d = 1'b0;
    end else if (capture) begin
      v_d = 1'b1;
    end else if (retire) begin
      v_d = 1'b0;
    end

    if (capture) begin
      rd_d        = rd;
      reg_write_d = reg_write;
      mis_d       = mem_read & ext_mis;
      wdata_d     = (mem_read & mem_to_reg) ? ext_data : alu_result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q         <= 1'b0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mis_q       <= 1'b0;
      wdata_q     <= '0;
      instret_q   <= '0;
    end else begin
      v_q         <= v_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      mis_q       <= mis_d;
      wdata_q     <= wdata_d;
      instret_q   <= instret_d;
    end
  end

  assign writes          = reg_write_q & (rd_q != 5'd0) & ~mis_q;
  assign rf_we           = retire & writes;
  assign rf_waddr        = rd_q;
  assign rf_wdata        = wdata_q;
  assign fwd_valid       = v_q & writes;
  assign fwd_rd          = rd_q;
  assign fwd_data        = wdata_q;
  assign load_misaligned = retire & mis_q;
  assign instret         = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage; a second instance with a 4-bit counter
// exercises instret wraparound.
module tb_wb_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush, wb_stall, reg_write, mem_to_reg, mem_read;
  logic [63:0] alu_result, read_data;
  logic [4:0]  rd;
  logic [2:0]  funct3;

  logic        in_ready, rf_we, fwd_valid, load_misaligned;
  logic [4:0]  rf_waddr, fwd_rd;
  logic [63:0] rf_wdata, fwd_data, instret;

  logic        w4_in_ready, w4_rf_we, w4_fwd_valid, w4_load_misaligned;
  logic [4:0]  w4_rf_waddr, w4_fwd_rd;
  logic [63:0] w4_rf_wdata, w4_fwd_data;
  logic [3:0]  w4_instret;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
    logic        we;
    logic        mis;
    logic        chk_data;
  } exp_t;

  typedef struct packed {
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] rdata;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        we;
    logic        mis;
  } ld_t;

  exp_t        sb[$];
  logic [63:0] exp_instret;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .wb_stall(wb_stall), .alu_result(alu_result),
    .read_data(read_data), .rd(rd), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .mem_read(mem_read), .funct3(funct3),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .load_misaligned(load_misaligned), .instret(instret)
  );

  wb_stage #(.CNT_W(4)) dut_w4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w4_in_ready),
    .flush(flush), .wb_stall(wb_stall), .alu_result(alu_result),
    .read_data(read_data), .rd(rd), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .mem_read(mem_read), .funct3(funct3),
    .rf_we(w4_rf_we), .rf_waddr(w4_rf_waddr), .rf_wdata(w4_rf_wdata),
    .fwd_valid(w4_fwd_valid), .fwd_rd(w4_fwd_rd), .fwd_data(w4_fwd_data),
    .load_misaligned(w4_load_misaligned), .instret(w4_instret)
  );

  task automatic set_in(input logic v, input logic fl, input logic st,
                        input logic [63:0] a, input logic [63:0] d,
                        input logic [4:0] r, input logic rw, input logic m2r,
                        input logic mr, input logic [2:0] f3);
    in_valid   = v;
    flush      = fl;
    wb_stall   = st;
    alu_result = a;
    read_data  = d;
    rd         = r;
    reg_write  = rw;
    mem_to_reg = m2r;
    mem_read   = mr;
    funct3     = f3;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_rf_we: got %0h want 0", rf_we); end
    checks++; if (fwd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_fwd_valid: got %0h want 0", fwd_valid); end
    checks++; if (load_misaligned !== 1'b0) begin errors++; $display("[TB] FAIL reset_misaligned: got %0h want 0", load_misaligned); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %0h want 1", in_ready); end
    checks++; if (instret !== 64'h0) begin errors++; $display("[TB] FAIL reset_instret: got %0h want 0", instret); end
    checks++; if (rf_wdata !== 64'h0 || fwd_data !== 64'h0) begin errors++; $display("[TB] FAIL reset_data: got %h/%h want 0", rf_wdata, fwd_data); end
    checks++; if (rf_waddr !== 5'd0 || fwd_rd !== 5'd0) begin errors++; $display("[TB] FAIL reset_addr: got %0d/%0d want 0", rf_waddr, fwd_rd); end
    reset = 1'b0;
    exp_instret = 64'h0;
    sb.delete();
  endtask

  task automatic test_loads();
    ld_t  tab[11];
    exp_t e;
    tab[0]  = '{F3_LB,  64'h1003, 64'h0000_0000_80FF_0000, 5'd5,  64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0};
    tab[1]  = '{F3_LBU, 64'h1003, 64'h0000_0000_80FF_0000, 5'd5,  64'h0000_0000_0000_0080, 1'b1, 1'b0};
    tab[2]  = '{F3_LW,  64'h1002, 64'h0000_0000_80FF_0000, 5'd6,  64'h0,                   1'b0, 1'b1};
    tab[3]  = '{F3_LD,  64'h1008, 64'h1122_3344_5566_7788, 5'd7,  64'h1122_3344_5566_7788, 1'b1, 1'b0};
    tab[4]  = '{F3_LH,  64'h1006, 64'h8001_0000_0000_0000, 5'd8,  64'hFFFF_FFFF_FFFF_8001, 1'b1, 1'b0};
    tab[5]  = '{F3_LHU, 64'h1006, 64'h8001_0000_0000_0000, 5'd9,  64'h0000_0000_0000_8001, 1'b1, 1'b0};
    tab[6]  = '{F3_LWU, 64'h1004, 64'hDEAD_BEEF_0000_0000, 5'd10, 64'h0000_0000_DEAD_BEEF, 1'b1, 1'b0};
    tab[7]  = '{3'b111, 64'h1000, 64'h1234_5678_9ABC_DEF0, 5'd11, 64'h0,                   1'b0, 1'b1};
    tab[8]  = '{F3_LW,  64'h1004, 64'h8765_4321_0000_0000, 5'd12, 64'hFFFF_FFFF_8765_4321, 1'b1, 1'b0};
    tab[9]  = '{F3_LH,  64'h1001, 64'h0000_0000_0000_FFFF, 5'd13, 64'h0,                   1'b0, 1'b1};
    tab[10] = '{F3_LD,  64'h1004, 64'h0102_0304_0506_0708, 5'd14, 64'h0,                   1'b0, 1'b1};
    for (int i = 0; i <= 11; i++) begin
      @(negedge clk);
      if (i < 11) begin
        set_in(1'b1, 1'b0, 1'b0, tab[i].addr, tab[i].rdata, tab[i].rd, 1'b1, 1'b1, 1'b1, tab[i].f3);
        sb.push_back('{tab[i].rd, tab[i].data, tab[i].we, tab[i].mis, ~tab[i].mis});
      end else begin
        idle();
      end
      #1;
      if (i > 0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("[TB] FAIL load_sb_empty: got 0 entries want 1");
        end else begin
          e = sb.pop_front();
          if (rf_we !== e.we) begin errors++; $display("[TB] FAIL load%0d_rf_we: got %0h want %0h", i-1, rf_we, e.we); end
          checks++; if (rf_waddr !== e.rd) begin errors++; $display("[TB] FAIL load%0d_waddr: got %0d want %0d", i-1, rf_waddr, e.rd); end
          if (e.chk_data) begin
            checks++; if (rf_wdata !== e.data) begin errors++; $display("[TB] FAIL load%0d_wdata: got %h want %h", i-1, rf_wdata, e.data); end
          end
          checks++; if (load_misaligned !== e.mis) begin errors++; $display("[TB] FAIL load%0d_misaligned: got %0h want %0h", i-1, load_misaligned, e.mis); end
          checks++; if (fwd_valid !== e.we) begin errors++; $display("[TB] FAIL load%0d_fwd_valid: got %0h want %0h", i-1, fwd_valid, e.we); end
          checks++; if (instret !== exp_instret) begin errors++; $display("[TB] FAIL load%0d_instret: got %0d want %0d", i-1, instret, exp_instret); end
          exp_instret++;
        end
      end
    end
  endtask

  task automatic test_alu();
    logic [4:0]  rds[3];
    logic        rws[3];
    logic [63:0] alus[3];
    logic        wes[3];
    exp_t        e;
    rds[0] = 5'd0; rws[0] = 1'b1; alus[0] = 64'h55;   wes[0] = 1'b0;
    rds[1] = 5'd3; rws[1] = 1'b1; alus[1] = 64'h1235; wes[1] = 1'b1;
    rds[2] = 5'd4; rws[2] = 1'b0; alus[2] = 64'h77;   wes[2] = 1'b0;
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      if (i < 3) begin
        set_in(1'b1, 1'b0, 1'b0, alus[i], 64'hFFFF_FFFF_FFFF_FFFF, rds[i], rws[i], 1'b0, 1'b0, F3_LH);
        sb.push_back('{rds[i], alus[i], wes[i], 1'b0, 1'b1});
      end else begin
        idle();
      end
      #1;
      if (i > 0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("[TB] FAIL alu_sb_empty: got 0 entries want 1");
        end else begin
          e = sb.pop_front();
          if (rf_we !== e.we) begin errors++; $display("[TB] FAIL alu%0d_rf_we: got %0h want %0h", i-1, rf_we, e.we); end
          checks++; if (fwd_valid !== e.we) begin errors++; $display("[TB] FAIL alu%0d_fwd_valid: got %0h want %0h", i-1, fwd_valid, e.we); end
          checks++; if (rf_wdata !== e.data) begin errors++; $display("[TB] FAIL alu%0d_wdata: got %h want %h", i-1, rf_wdata, e.data); end
          checks++; if (load_misaligned !== 1'b0) begin errors++; $display("[TB] FAIL alu%0d_misaligned: got %0h want 0", i-1, load_misaligned); end
          checks++; if (instret !== exp_instret) begin errors++; $display("[TB] FAIL alu%0d_instret: got %0d want %0d", i-1, instret, exp_instret); end
          exp_instret++;
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    set_in(1'b1, 1'b0, 1'b0, 64'h10, 64'h0, 5'd1, 1'b1, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    set_in(1'b1, 1'b0, 1'b0, 64'h20, 64'h0, 5'd2, 1'b1, 1'b0, 1'b0, 3'b000);
    #1;
    checks++; if (rf_we !== 1'b1 || rf_wdata !== 64'h10 || rf_waddr !== 5'd1) begin errors++; $display("[TB] FAIL b2b_first: got we=%0h d=%h a=%0d want we=1 d=10 a=1", rf_we, rf_wdata, rf_waddr); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready: got %0h want 1", in_ready); end
    exp_instret++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_in(1'b1, 1'b0, 1'b1, 64'h30, 64'h0, 5'd9, 1'b1, 1'b0, 1'b0, 3'b000);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall%0d_in_ready: got %0h want 0", k, in_ready); end
      checks++; if (rf_we !== 1'b0) begin errors++; $display("[TB] FAIL stall%0d_rf_we: got %0h want 0", k, rf_we); end
      checks++; if (fwd_valid !== 1'b1 || fwd_data !== 64'h20 || fwd_rd !== 5'd2) begin errors++; $display("[TB] FAIL stall%0d_fwd: got v=%0h d=%h rd=%0d want v=1 d=20 rd=2", k, fwd_valid, fwd_data, fwd_rd); end
      checks++; if (instret !== exp_instret) begin errors++; $display("[TB] FAIL stall%0d_instret: got %0d want %0d", k, instret, exp_instret); end
    end
    @(negedge clk);
    idle();
    #1;
    checks++; if (rf_we !== 1'b1 || rf_wdata !== 64'h20 || rf_waddr !== 5'd2) begin errors++; $display("[TB] FAIL release_retire: got we=%0h d=%h a=%0d want we=1 d=20 a=2", rf_we, rf_wdata, rf_waddr); end
    exp_instret++;
    @(negedge clk);
    #1;
    checks++; if (rf_we !== 1'b0 || fwd_valid !== 1'b0) begin errors++; $display("[TB] FAIL release_once: got we=%0h fv=%0h want 0/0", rf_we, fwd_valid); end
    checks++; if (instret !== exp_instret) begin errors++; $display("[TB] FAIL release_instret: got %0d want %0d", instret, exp_instret); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    set_in(1'b1, 1'b1, 1'b0, 64'h77, 64'h0, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    set_in(1'b1, 1'b0, 1'b0, 64'h88, 64'h0, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000);
    #1;
    checks++; if (fwd_valid !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_capture: got fv=%0h we=%0h want 0/0", fwd_valid, rf_we); end
    checks++; if (instret !== exp_instret) begin errors++; $display("[TB] FAIL flush_instret: got %0d want %0d", instret, exp_instret); end
    @(negedge clk);
    set_in(1'b1, 1'b1, 1'b0, 64'h99, 64'h0, 5'd4, 1'b1, 1'b0, 1'b0, 3'b000);
    #1;
    checks++; if (rf_we !== 1'b1 || rf_wdata !== 64'h88) begin errors++; $display("[TB] FAIL flush_retire: got we=%0h d=%h want we=1 d=88", rf_we, rf_wdata); end
    exp_instret++;
    @(negedge clk);
    set_in(1'b1, 1'b0, 1'b0, 64'hAA, 64'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000);
    #1;
    checks++; if (fwd_valid !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("[TB] FAIL flush_drop: got fv=%0h we=%0h want 0/0", fwd_valid, rf_we); end
    checks++; if (instret !== exp_instret) begin errors++; $display("[TB] FAIL flush_drop_instret: got %0d want %0d", instret, exp_instret); end
    @(negedge clk);
    set_in(1'b0, 1'b1, 1'b1, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
    #1;
    checks++; if (fwd_valid !== 1'b1 || rf_we !== 1'b0 || fwd_data !== 64'hAA) begin errors++; $display("[TB] FAIL flush_stalled_hold: got fv=%0h we=%0h d=%h want 1/0/aa", fwd_valid, rf_we, fwd_data); end
    @(negedge clk);
    idle();
    #1;
    checks++; if (fwd_valid !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("[TB] FAIL flush_stalled_drop: got fv=%0h we=%0h want 0/0", fwd_valid, rf_we); end
    checks++; if (instret !== exp_instret) begin errors++; $display("[TB] FAIL flush_stalled_instret: got %0d want %0d", instret, exp_instret); end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 16 && exp_instret[3:0] != 4'hF; k++) begin
      @(negedge clk);
      set_in(1'b1, 1'b0, 1'b0, 64'h1, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
      @(negedge clk);
      idle();
      exp_instret++;
    end
    @(negedge clk);
    #1;
    checks++; if (w4_instret !== 4'hF) begin errors++; $display("[TB] FAIL wrap_all_ones: got %0h want f", w4_instret); end
    set_in(1'b1, 1'b0, 1'b0, 64'h1, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    idle();
    exp_instret++;
    @(negedge clk);
    #1;
    checks++; if (w4_instret !== 4'h0) begin errors++; $display("[TB] FAIL wrap_zero: got %0h want 0", w4_instret); end
    checks++; if (instret !== exp_instret) begin errors++; $display("[TB] FAIL wrap_instret64: got %0d want %0d", instret, exp_instret); end
  endtask

  task automatic test_reset_mid_stall();
    @(negedge clk);
    set_in(1'b1, 1'b0, 1'b0, 64'hAB, 64'h0, 5'd2, 1'b1, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b1, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000);
    #1;
    checks++; if (in_ready !== 1'b0 || fwd_valid !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_stall: got rdy=%0h fv=%0h want 0/1", in_ready, fwd_valid); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_stall_in_ready: got %0h want 1", in_ready); end
    checks++; if (rf_we !== 1'b0 || fwd_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_stall_we: got we=%0h fv=%0h want 0/0", rf_we, fwd_valid); end
    checks++; if (instret !== 64'h0 || w4_instret !== 4'h0) begin errors++; $display("[TB] FAIL rst_stall_instret: got %0d/%0d want 0", instret, w4_instret); end
    exp_instret = 64'h0;
    idle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_loads();
    test_alu();
    test_back_to_back();
    test_flush();
    test_wrap();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
